// File: rtl/gus16_irq_ctrl.sv
// gus16_irq_ctrl: synchronises, latches, masks and priority-encodes interrupt sources for the GUS16 core.
// Optional software interrupts through offset-3 writes are enabled by defining GUS_IRQCTL_SWI_EN.
module gus16_irq_ctrl #(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'hFFE0,
  parameter int          HOLD = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NSRC-1:0] src,
  input  logic [15:0]     ca,
  input  logic [15:0]     cdo,
  input  logic            we,
  output logic [15:0]     rdo,
  output logic            sel,
  output logic            irq,
  output logic [2:0]      ivector,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [NSRC-1:0] meta_q, sync_q, prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] evt, pend_rd, act, wdata, w1c, swi_set;
  logic [7:0]      act8, sync8;
  state_t          state_q;
  logic            irq_q;
  logic [2:0]      ivec_q;
  logic [3:0]      cnt_q;
  logic            win_any;
  logic [2:0]      win;
  logic            window, wr;
  logic            unused_cdo;

  assign window     = (ca[15:2] == BASE[15:2]);
  assign wr         = we & window;
  assign sel        = window & ~we;
  assign wdata      = cdo[NSRC-1:0];
  assign unused_cdo = ^cdo;

  // Two synchroniser flops followed by a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= src;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign evt     = sync_q & ~prev_q;
  // Level-mode bits are never stored; they read straight from the synchronised input.
  assign pend_rd = pend_q | (sync_q & ~edge_q);
  assign act     = pend_rd & mask_q;
  assign act8    = 8'(act);
  assign sync8   = 8'(sync_q);

  always_comb begin
    mask_d  = mask_q;
    edge_d  = edge_q;
    w1c     = '0;
    swi_set = '0;
    if (wr) begin
      case (ca[1:0])
        2'd0: w1c    = wdata;
        2'd1: mask_d = wdata;
        2'd2: edge_d = wdata;
`ifdef GUS_IRQCTL_SWI_EN
        2'd3: swi_set = wdata;
`endif
        default: ;
      endcase
    end
    // Sets are applied after clears so a same-cycle event wins; dropping EDGE clears the latch.
    pend_d = ((pend_q & ~w1c) | ((evt | swi_set) & edge_q)) & edge_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '1;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  always_comb begin
    win_any = |act;
    win     = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) win = 3'(i);
    end
  end

  // The last HOLDOFF cycle arbitrates directly so irq stays low for exactly HOLD cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      ivec_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            ivec_q  <= win;
            irq_q   <= 1'b1;
            state_q <= ASSERT;
          end
        end
        ASSERT: begin
          if (!act8[ivec_q]) begin
            irq_q   <= 1'b0;
            cnt_q   <= 4'(HOLD);
            state_q <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt_q <= 4'd1) begin
            if (win_any) begin
              ivec_q  <= win;
              irq_q   <= 1'b1;
              state_q <= ASSERT;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdo = '0;
    if (window) begin
      case (ca[1:0])
        2'd0:    rdo = 16'(pend_rd);
        2'd1:    rdo = 16'(mask_q);
        2'd2:    rdo = 16'(edge_q);
        default: rdo = {irq_q, state_q, ivec_q, 2'b00, sync8};
      endcase
    end
  end

  assign irq       = irq_q;
  assign ivector   = ivec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gus16_irq_ctrl.sv
// Bench for gus16_irq_ctrl: scripted and random source activity, irq/read scoreboard, summary line.
// Handshake: a bus read is presented for one cycle with sel=1; irq edges are matched to queued events.
module tb_gus16_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFFE0;
  localparam int          HOLD = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  src = '0;
  logic [15:0] ca = '0;
  logic [15:0] cdo = '0;
  logic        we = 1'b0;
  logic [15:0] rdo;
  logic        sel;
  logic        irq;
  logic [2:0]  ivector;
  logic [1:0]  dbg_state;

  gus16_irq_ctrl #(.NSRC(8), .BASE(BASE), .HOLD(HOLD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .src       (src),
    .ca        (ca),
    .cdo       (cdo),
    .we        (we),
    .rdo       (rdo),
    .sel       (sel),
    .irq       (irq),
    .ivector   (ivector),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: irq events are {rise, vector, cycle}
  logic [35:0] exp_q[$];
  logic [15:0] rd_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        irq_prev = 1'b0;

  // monitor: samples 1 time unit after each rising edge
  always begin
    logic [35:0] e;
    logic [15:0] r;
    @(posedge clk);
    cyc++;
    #1;
    if (irq !== irq_prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL irq_event: irq went to %0b (ivector %0d) at cycle %0d, required no change", irq, ivector, cyc);
      end else begin
        e = exp_q.pop_front();
        if (irq !== e[35] || cyc != int'(e[31:0]) || (e[35] && ivector !== e[34:32])) begin
          n_fail++;
          $display("FAIL irq_event: got irq=%0b ivector=%0d at cycle %0d, required irq=%0b ivector=%0d at cycle %0d",
                   irq, ivector, cyc, e[35], e[34:32], int'(e[31:0]));
        end
      end
      irq_prev = irq;
    end
    if (sel === 1'b1) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_read: unexpected read of ca=%h, rdo=%h", ca, rdo);
      end else begin
        r = rd_q.pop_front();
        if (rdo !== r) begin
          n_fail++;
          $display("FAIL bus_read: ca=%h rdo=%h, required %h (cycle %0d)", ca, rdo, r, cyc);
        end
      end
    end
  end

  // driver tasks; all start and end at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [15:0] d);
    ca  = {BASE[15:2], off};
    cdo = d;
    we  = 1'b1;
    @(negedge clk);
    we  = 1'b0;
    ca  = '0;
    cdo = '0;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [15:0] exp_val);
    rd_q.push_back(exp_val);
    ca = {BASE[15:2], off};
    we = 1'b0;
    @(negedge clk);
    ca = '0;
  endtask

  task automatic expect_rise(input int vec, input int at);
    exp_q.push_back({1'b1, 3'(vec), 32'(at)});
  endtask

  task automatic expect_fall(input int at);
    exp_q.push_back({1'b0, 3'b000, 32'(at)});
  endtask

  task automatic check(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act_v, exp_v);
    end
  endtask

  // reference model helper: highest-priority (lowest) set index
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  logic [7:0] pulses, mask, pending;
  int         c, w, d;

  initial begin
    #1 resetn = 1'b0;
    @(negedge clk);

    // reset values, read while reset is held
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_ivector", 16'(ivector), 16'h0000);
    bus_read(2'd2, 16'h00FF);
    bus_read(2'd1, 16'h0000);
    bus_read(2'd0, 16'h0000);
    bus_read(2'd3, 16'h0000);
    resetn = 1'b1;
    tick(3);

    // single edge source: latency, PEND view, W1C and holdoff
    bus_write(2'd1, 16'h0004);
    c = cyc;
    expect_rise(2, c + 4);
    src = 8'h04;
    tick(1);
    src = 8'h00;
    tick(3);
    check("assert_state", 16'(dbg_state), 16'h0001);
    bus_read(2'd0, 16'h0004);
    w = cyc;
    expect_fall(w + 2);
    bus_write(2'd0, 16'h0004);
    tick(8);

    // lower-priority vector held while a higher one arrives later
    bus_write(2'd1, 16'h0030);
    c = cyc;
    expect_rise(5, c + 4);
    src = 8'h20;
    tick(1);
    src = 8'h00;
    tick(4);
    src = 8'h10;
    tick(1);
    src = 8'h00;
    tick(4);
    bus_read(2'd3, 16'hB400);
    w = cyc;
    expect_fall(w + 2);
    expect_rise(4, w + 2 + HOLD);
    bus_write(2'd0, 16'h0020);
    tick(4);
    w = cyc;
    expect_fall(w + 2);
    bus_write(2'd0, 16'h0010);
    tick(6);
    bus_write(2'd1, 16'h0000);

    // level source: W1C ignored, irq follows the input
    bus_write(2'd2, 16'h00FE);
    bus_write(2'd1, 16'h0001);
    c = cyc;
    expect_rise(0, c + 3);
    src = 8'h01;
    tick(4);
    bus_write(2'd0, 16'h0001);
    tick(2);
    bus_read(2'd0, 16'h0001);
    d = cyc;
    expect_fall(d + 3);
    src = 8'h00;
    tick(7);
    bus_write(2'd1, 16'h0000);
    bus_write(2'd2, 16'h00FF);
    tick(2);

    // edge event and W1C land on the same clock: set wins
    c = cyc;
    src = 8'h08;
    tick(1);
    src = 8'h00;
    tick(1);
    bus_write(2'd0, 16'h0008);
    bus_read(2'd0, 16'h0008);
    w = cyc;
    expect_rise(3, w + 2);
    bus_write(2'd1, 16'h0008);
    tick(4);
    // asynchronous reset while irq is high
    w = cyc;
    expect_fall(w + 1);
    resetn = 1'b0;
    #1;
    check("reset_mid_irq", 16'(irq), 16'h0000);
    check("reset_mid_ivector", 16'(ivector), 16'h0000);
    tick(2);
    resetn = 1'b1;
    tick(3);
    bus_read(2'd1, 16'h0000);
    bus_read(2'd0, 16'h0000);

    // software interrupt through offset 3
    bus_write(2'd1, 16'h0080);
`ifdef GUS_IRQCTL_SWI_EN
    c = cyc;
    expect_rise(7, c + 2);
    bus_write(2'd3, 16'h0080);
    tick(3);
    bus_read(2'd0, 16'h0080);
    w = cyc;
    expect_fall(w + 2);
    bus_write(2'd0, 16'h0080);
    tick(5);
`else
    bus_write(2'd3, 16'h0080);
    tick(3);
    bus_read(2'd0, 16'h0000);
`endif
    bus_write(2'd1, 16'h0000);
    tick(2);

    // random rounds: simultaneous edge pulses, random mask, serviced in priority order
    for (int r = 0; r < 30; r++) begin
      pulses = 8'($urandom_range(1, 255));
      mask   = 8'($urandom_range(0, 255));
      bus_write(2'd1, {8'h00, mask});
      pending = pulses;
      c = cyc;
      if ((pending & mask) != 0) expect_rise(lowest(pending & mask), c + 4);
      src = pulses;
      tick(1);
      src = 8'h00;
      tick(3);
      bus_read(2'd0, {8'h00, pulses});
      while ((pending & mask) != 0) begin
        tick($urandom_range(0, 3));
        pending[lowest(pending & mask)] = 1'b0;
        w = cyc;
        expect_fall(w + 2);
        if ((pending & mask) != 0) expect_rise(lowest(pending & mask), w + 2 + HOLD);
        bus_write(2'd0, 16'(~pending & pulses & mask));
        tick(HOLD + 1);
      end
      tick(HOLD + 3);
      bus_write(2'd0, 16'h00FF);
      bus_read(2'd0, 16'h0000);
    end

    tick(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL irq_pending: %0d irq events never observed, required 0", exp_q.size());
    end
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_pending: %0d reads never observed, required 0", rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
